// File: rtl/axil_seq_master.sv
// AXI4-Lite self-test master: writes NUM_REGS words seed+i, then reads them back and counts mismatches/error responses.
// Optional response watchdog enabled by defining AXIL_SEQ_TIMEOUT_EN.
module axil_seq_master #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_REGS       = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  input  logic [31:0]             seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [7:0]              err_cnt,
  output logic                    timeout,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);

  state_t                state, state_d;
  logic [7:0]            idx, idx_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [7:0]            err_cnt_d;
  logic                  pass_d;
  logic                  aw_done, aw_done_d, w_done, w_done_d;
  logic                  err_inc, clear_stats, is_last;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] exp_data;

`ifdef AXIL_SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt, wd_cnt_d;
  logic        timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // One address/data pair serves both phases; idx only moves on state transitions, so payloads stay stable.
  assign addr     = BASE_ADDR + ADDR_WIDTH'({idx, 2'b00});
  assign exp_data = seed_q + DATA_WIDTH'(idx);
  assign is_last  = (idx == LAST_IDX);

  assign M_AXI_AWADDR  = addr;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_WDATA   = exp_data;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = (state == WR_REQ) && !aw_done;
  assign M_AXI_WVALID  = (state == WR_REQ) && !w_done;
  assign M_AXI_BREADY  = (state == WR_RESP);
  assign M_AXI_ARVALID = (state == RD_REQ);
  assign M_AXI_RREADY  = (state == RD_RESP);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  always_comb begin
    // NOTE: every signal written here is given a default first, so no latch can be inferred.
    state_d     = state;
    idx_d       = idx;
    seed_d      = seed_q;
    aw_done_d   = aw_done;
    w_done_d    = w_done;
    err_inc     = 1'b0;
    clear_stats = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          idx_d       = '0;
          seed_d      = DATA_WIDTH'(seed);
          clear_stats = 1'b1;
          state_d     = WR_REQ;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
        w_done_d  = w_done  | (M_AXI_WVALID  & M_AXI_WREADY);
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          err_inc = (M_AXI_BRESP != 2'b00);
          if (is_last) begin
            idx_d   = '0;
            state_d = RD_REQ;
          end else begin
            idx_d   = idx + 8'd1;
            state_d = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (M_AXI_ARREADY) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (M_AXI_RVALID) begin
          err_inc = (M_AXI_RDATA != exp_data) || (M_AXI_RRESP != 2'b00);
          if (is_last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx + 8'd1;
            state_d = RD_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef AXIL_SEQ_TIMEOUT_EN
    // Any state change restarts the watchdog; staying in a waiting state counts one stalled cycle.
    timeout_d = clear_stats ? 1'b0 : timeout_q;
    wd_cnt_d  = '0;
    if ((state_d == state) && (state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP})) begin
      if (wd_cnt == WD_LAST) begin
        state_d   = DONE;
        err_inc   = 1'b1;
        timeout_d = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end else begin
        wd_cnt_d = wd_cnt + 16'd1;
      end
    end
`endif

    err_cnt_d = err_cnt;
    if (clear_stats)                         err_cnt_d = '0;
    else if (err_inc && (err_cnt != 8'hFF)) err_cnt_d = err_cnt + 8'd1;

    // pass is resolved on entry to DONE so it already reflects the final error of the sequence.
    pass_d = pass;
    if (clear_stats)                              pass_d = 1'b0;
    else if ((state_d == DONE) && (state != DONE)) pass_d = (err_cnt_d == 8'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      idx       <= '0;
      seed_q    <= '0;
      err_cnt   <= '0;
      pass      <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
`ifdef AXIL_SEQ_TIMEOUT_EN
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      seed_q    <= seed_d;
      err_cnt   <= err_cnt_d;
      pass      <= pass_d;
      aw_done   <= aw_done_d;
      w_done    <= w_done_d;
`ifdef AXIL_SEQ_TIMEOUT_EN
      wd_cnt    <= wd_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_axil_seq_master.sv
// Scoreboard bench for axil_seq_master: a behavioural AXI4-Lite slave with a fault plan, expected
// transactions/results queued at start, and an independent monitor that pops and compares them.
module tb_axil_seq_master;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic        busy, done, pass, timeout;
  logic [7:0]  err_cnt;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  axil_seq_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(N), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .timeout(timeout),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one accepted sequence.
  typedef struct {
    int err;
    int lat;   // start-to-done cycles, -1 when the slave adds random waits
    int tmo;
    int nb;
    int nr;
  } res_t;

  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];
  logic [31:0] exp_ar[$];
  res_t        exp_res[$];
  int          start_cyc = 0;
  int          done_seen = 0;
  int          b_seen = 0;
  int          r_seen = 0;

  // Slave behaviour: 0 zero-wait, 1 random waits, 2 AWREADY held low 3 cycles, 3 never respond on B.
  int          mode = 0;
  logic [N-1:0] b_err = '0, r_bad = '0, r_err = '0;
  int          wr_k = 0, rd_k = 0;
  logic [31:0] mem [logic [31:0]];

  initial begin
    logic [31:0] s_awaddr, s_wdata, s_araddr, c_awaddr, c_wdata, c_araddr, d;
    bit s_rst, aw_hs, w_hs, b_hs, ar_hs, r_hs, have_aw, have_w;
    int b_wait, r_wait, aw_stall;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
    have_aw = 0; have_w = 0; b_wait = -1; r_wait = -1; aw_stall = 0;
    s_awaddr = 0; s_wdata = 0; s_araddr = 0;
    forever begin
      @(negedge ACLK);
      s_rst = ARESET;
      aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
      w_hs  = M_AXI_WVALID && M_AXI_WREADY;
      b_hs  = M_AXI_BVALID && M_AXI_BREADY;
      ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
      r_hs  = M_AXI_RVALID && M_AXI_RREADY;
      c_awaddr = M_AXI_AWADDR; c_wdata = M_AXI_WDATA; c_araddr = M_AXI_ARADDR;
      if (aw_hs || !M_AXI_AWVALID) aw_stall = 0;
      else                         aw_stall++;
      @(posedge ACLK);
      #2;
      if (s_rst) begin
        M_AXI_BVALID = 0; M_AXI_RVALID = 0;
        have_aw = 0; have_w = 0; b_wait = -1; r_wait = -1; aw_stall = 0;
      end else begin
        if (aw_hs) begin have_aw = 1; s_awaddr = c_awaddr; end
        if (w_hs)  begin have_w = 1;  s_wdata  = c_wdata;  end
        if (b_hs)  begin M_AXI_BVALID = 0; wr_k++; end
        if (have_aw && have_w) begin
          mem[s_awaddr] = s_wdata;
          have_aw = 0; have_w = 0;
          b_wait = (mode == 1) ? int'($urandom_range(0, 3)) : (mode == 3) ? -1 : 0;
        end
        if (b_wait == 0) begin
          M_AXI_BVALID = 1;
          M_AXI_BRESP  = b_err[wr_k % N] ? 2'b10 : 2'b00;
        end
        if (b_wait >= 0) b_wait--;
        if (r_hs)  begin M_AXI_RVALID = 0; rd_k++; end
        if (ar_hs) begin
          s_araddr = c_araddr;
          r_wait = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
        end
        if (r_wait == 0) begin
          d = mem.exists(s_araddr) ? mem[s_araddr] : 32'h0;
          M_AXI_RVALID = 1;
          M_AXI_RDATA  = r_bad[rd_k % N] ? ((d != 0) ? 32'h0 : 32'h1) : d;
          M_AXI_RRESP  = r_err[rd_k % N] ? 2'b10 : 2'b00;
        end
        if (r_wait >= 0) r_wait--;
      end
      case (mode)
        1: begin
          M_AXI_AWREADY = ($urandom_range(0, 2) != 0);
          M_AXI_WREADY  = ($urandom_range(0, 2) != 0);
          M_AXI_ARREADY = ($urandom_range(0, 2) != 0);
        end
        2: begin
          M_AXI_AWREADY = (aw_stall >= 3);
          M_AXI_WREADY  = 1; M_AXI_ARREADY = 1;
        end
        default: begin
          M_AXI_AWREADY = 1; M_AXI_WREADY = 1; M_AXI_ARREADY = 1;
        end
      endcase
    end
  end

  // Monitor: compares every handshake and every done pulse against the queued expectations.
  bit          aw_pend = 0, w_pend = 0, ar_pend = 0, pass_pend = 0;
  logic [31:0] aw_prev = 0, w_prev = 0, ar_prev = 0;
  logic        pass_exp = 0;

  always @(negedge ACLK) begin
    res_t r;
    if (ARESET) begin
      aw_pend = 0; w_pend = 0; ar_pend = 0; pass_pend = 0;
    end else begin
      if (pass_pend) begin
        check("pass", 32'(pass), 32'(pass_exp));
        pass_pend = 0;
      end
      if (aw_pend) begin
        check("awvalid_hold", 32'(M_AXI_AWVALID), 32'd1);
        check("awaddr_hold", M_AXI_AWADDR, aw_prev);
      end
      if (w_pend) begin
        check("wvalid_hold", 32'(M_AXI_WVALID), 32'd1);
        check("wdata_hold", M_AXI_WDATA, w_prev);
      end
      if (ar_pend) begin
        check("arvalid_hold", 32'(M_AXI_ARVALID), 32'd1);
        check("araddr_hold", M_AXI_ARADDR, ar_prev);
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        check("aw_expected", 32'(exp_aw.size() > 0), 32'd1);
        if (exp_aw.size() > 0) check("awaddr", M_AXI_AWADDR, exp_aw.pop_front());
        check("awprot", 32'(M_AXI_AWPROT), 32'd0);
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        check("w_expected", 32'(exp_w.size() > 0), 32'd1);
        if (exp_w.size() > 0) check("wdata", M_AXI_WDATA, exp_w.pop_front());
        check("wstrb", 32'(M_AXI_WSTRB), 32'hF);
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        check("ar_expected", 32'(exp_ar.size() > 0), 32'd1);
        if (exp_ar.size() > 0) check("araddr", M_AXI_ARADDR, exp_ar.pop_front());
        check("arprot", 32'(M_AXI_ARPROT), 32'd0);
      end
      if (M_AXI_BVALID && M_AXI_BREADY) b_seen++;
      if (M_AXI_RVALID && M_AXI_RREADY) r_seen++;
      if (done) begin
        check("done_expected", 32'(exp_res.size() > 0), 32'd1);
        if (exp_res.size() > 0) begin
          r = exp_res.pop_front();
          check("err_cnt", 32'(err_cnt), 32'(r.err));
          check("timeout", 32'(timeout), 32'(r.tmo));
          check("b_count", 32'(b_seen), 32'(r.nb));
          check("r_count", 32'(r_seen), 32'(r.nr));
          if (r.lat >= 0) check("latency", 32'(cyc - start_cyc), 32'(r.lat));
          pass_exp  = (r.err == 0);
          pass_pend = 1;
        end
        done_seen++;
      end
      aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY; aw_prev = M_AXI_AWADDR;
      w_pend  = M_AXI_WVALID && !M_AXI_WREADY;   w_prev  = M_AXI_WDATA;
      ar_pend = M_AXI_ARVALID && !M_AXI_ARREADY; ar_prev = M_AXI_ARADDR;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic flush();
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_res.delete();
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin tick(); t++; end
    check("idle_within_bound", 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    ARESET = 1;
    flush();
    tick();
    ARESET = 0;
  endtask

  // Queues the expected transactions and result for one sequence and issues the start pulse.
  task automatic launch(input int m, input logic [31:0] s, input logic [N-1:0] be,
                        input logic [N-1:0] rb, input logic [N-1:0] re);
    res_t r;
    int   e;
    wait_idle();
    mode = m; b_err = be; r_bad = rb; r_err = re;
    wr_k = 0; rd_k = 0; b_seen = 0; r_seen = 0;
    for (int i = 0; i < N; i++) begin
      exp_aw.push_back(BASE + 32'(4 * i));
      exp_w.push_back(s + 32'(i));
      exp_ar.push_back(BASE + 32'(4 * i));
    end
    e     = $countones(be) + $countones(rb | re);
    r.err = (e > 255) ? 255 : e;
    r.lat = (m == 0) ? 4 * N + 1 : -1;
    r.tmo = 0; r.nb = N; r.nr = N;
    if (m == 3) begin
      r.err = 1; r.tmo = 1; r.nb = 0; r.nr = 0;
    end
    exp_res.push_back(r);
    seed = s; start = 1; start_cyc = cyc;
    tick();
    start = 0;
  endtask

  task automatic finish_seq(input bit noisy);
    int d0 = done_seen - 0;
    int t = 0;
    d0 = done_seen;
    if (done) d0 = done_seen - 1;
    while (done_seen == d0 && t < 600) begin
      if (noisy && busy && $urandom_range(0, 5) == 0) begin start = 1; seed = $urandom; end
      tick();
      start = 0;
      t++;
    end
    check("done_within_bound", 32'(done_seen != d0), 32'd1);
    if (done_seen == d0) apply_reset();
  endtask

  task automatic run_seq(input int m, input logic [31:0] s, input logic [N-1:0] be,
                         input logic [N-1:0] rb, input logic [N-1:0] re, input bit noisy);
    int d0;
    d0 = done_seen;
    launch(m, s, be, rb, re);
    if (done_seen != d0) return;
    finish_seq(noisy);
  endtask

  initial begin
    int d0, t;
    // Reset state, including a start that coincides with reset.
    repeat (3) tick();
    start = 1;
    tick();
    start = 0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}), 32'd0);
    check("rst_readies", 32'({M_AXI_BREADY, M_AXI_RREADY}), 32'd0);
    ARESET = 0;
    tick();
    check("start_in_reset_ignored", 32'(busy), 32'd0);

    run_seq(0, 32'h0000_0001, '0, '0, '0, 0);
    run_seq(2, $urandom, '0, '0, '0, 0);
    run_seq(0, 32'h0000_0001, '0, 4'b0100, 4'b1000, 0);
    run_seq(0, 32'hFFFF_FFFF, '0, '0, '0, 0);
    repeat (3) tick();
    check("pass_held", 32'(pass), 32'd1);

    // Reset during RD_RESP after a write error has been counted.
    launch(0, 32'h1234_5678, 4'b0001, '0, '0);
    t = 0;
    while (!M_AXI_RREADY && t < 100) begin tick(); t++; end
    check("reached_rd_resp", 32'(M_AXI_RREADY), 32'd1);
    check("err_before_reset", 32'(err_cnt), 32'd1);
    d0 = done_seen;
    apply_reset();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rready", 32'(M_AXI_RREADY), 32'd0);
    check("abort_err_cnt", 32'(err_cnt), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (6) tick();
    check("abort_no_done", 32'(done_seen), 32'(d0));
    run_seq(0, 32'hA5A5_0000, '0, '0, '0, 0);

    for (int k = 0; k < 12; k++) begin
      logic [N-1:0] be, rb, re;
      be = N'($urandom & $urandom);
      rb = N'($urandom & $urandom);
      re = N'($urandom & $urandom & $urandom);
      run_seq(1, $urandom, be, rb, re, 1);
    end

`ifdef AXIL_SEQ_TIMEOUT_EN
    run_seq(3, 32'h0000_0001, '0, '0, '0, 0);
    repeat (2) tick();
    check("timeout_sticky", 32'(timeout), 32'd1);
    flush();
    mode = 0;
    run_seq(0, 32'h0000_0040, '0, '0, '0, 0);
`endif

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_seq_master.md
# axil_seq_master

Synthesizable AXI4-Lite master that sits directly upstream of the bec_ip_2 slave register bank and drives its S00_AXI port. On a start pulse it writes NUM_REGS sequential words, then reads them back and compares them in hardware. It reports busy/done/pass and an error count. It gives on-board self-test of the slave, replacing a simulation-only VIP master.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; only 32 is supported
- NUM_REGS, 4, number of sequential words written and read back (1..256)
- BASE_ADDR, 0, byte address of the first word; word i is at BASE_ADDR + 4*i
- TIMEOUT_CYCLES, 256, response watchdog limit (only used with AXIL_SEQ_TIMEOUT_EN)

Ports:
- ACLK  in  1  clock; all logic on the rising edge
- ARESET  in  1  synchronous, active-high reset
- start  in  1  one-cycle start request
- seed  in  32  data for word 0; word i = seed + i (mod 2^32); sampled when start is accepted
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- pass  out  1  high after done if err_cnt == 0; held until the next accepted start
- err_cnt  out  8  mismatch/response error count, saturating at 255
- timeout  out  1  sticky watchdog abort flag (tied 0 without the macro)
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels
  - AWPROT = ARPROT = 0
  - WSTRB = 4'hF

## Operation
FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.

- **IDLE:** start=1 loads idx=0, latches seed, clears err_cnt/pass/timeout, and enters WR_REQ. start is ignored in every other state.
- **WR_REQ:** AWVALID and WVALID assert together with addr/data for idx.
  - Each valid drops independently on its own handshake.
  - When both handshakes have completed (same or different cycles), go to WR_RESP.
- **WR_RESP:** BREADY=1. On BVALID:
  - BRESP != OKAY increments err_cnt.
  - If idx == NUM_REGS-1: idx=0 and go to RD_REQ; else idx++ and go to WR_REQ.
- **RD_REQ:** ARVALID with the address for idx; on ARREADY go to RD_RESP.
- **RD_RESP:** RREADY=1. On RVALID:
  - err_cnt increments once if RDATA != seed+idx or RRESP != OKAY (one increment even if both are wrong).
  - If this is the last word, go to DONE; else idx++ and go to RD_REQ.
- **DONE:** done=1 for one cycle; pass = (err_cnt_next == 0); return to IDLE.
- busy = 1 in every state except IDLE.
- Address arithmetic: BASE_ADDR + 4*idx, truncated to ADDR_WIDTH (wraps silently).
- err_cnt saturates at 255; further errors leave it at 255.
- Valid/data stability: once asserted, a VALID and its payload hold until the handshake. VALID never depends combinationally on READY.

## Timing
- Reset values: all VALIDs 0, BREADY/RREADY 0, busy/done/pass/timeout 0, err_cnt 0, state IDLE.
- start is sampled at edge N; AWVALID/WVALID are high from cycle N+1.
- Per-transaction cost is 2 cycles with a zero-wait slave (READY in the same cycle as VALID, response in the next cycle). done is high in cycle N + 4*NUM_REGS + 1.
- ARESET high mid-sequence: at that edge all outputs return to reset values and the sequence is abandoned; no done pulse. This AXI valid-drop is permitted only under reset.
- start coincident with ARESET is ignored.

## Configuration
- AXIL_SEQ_TIMEOUT_EN defined: a 16-bit counter clears on entry to WR_REQ/WR_RESP/RD_REQ/RD_RESP and counts while the awaited handshake is missing.
  - Reaching TIMEOUT_CYCLES sets timeout=1, increments err_cnt, deasserts all VALID/READY, and enters DONE (pass=0).
- Undefined: no counter; the FSM waits indefinitely; timeout is constant 0.

## Test plan
- Zero-wait slave, seed=32'h1, NUM_REGS=4: writes 1,2,3,4 to 0x0,0x4,0x8,0xC; reads match -> done at start+17 cycles, pass=1, err_cnt=0.
- Slave holds AWREADY low 3 cycles while WREADY is immediate: WVALID drops after 1 cycle, AWVALID holds with stable AWADDR, and one B is accepted -> pass=1.
- Slave corrupts word 2 on read (returns 0) and returns SLVERR on word 3 -> err_cnt=2, pass=0.
- seed=32'hFFFFFFFF -> expected data FFFFFFFF,0,1,2; matching slave -> pass=1.
- ARESET asserted during RD_RESP -> next cycle busy=0, RREADY=0, err_cnt=0, no done; a new start then completes with pass=1.
- With AXIL_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts BVALID -> timeout=1, done pulses, err_cnt=1, pass=0.
